// File: rtl/datapath_ctrl_if.sv
// Handshake and control-strobe bundle between the datapath sequencer and the
// 16-bit register-file/shifter/ALU datapath.
interface datapath_ctrl_if #(
    parameter int unsigned W = 16
) ();
    logic         start;
    logic [15:0]  instr;
    logic         busy;
    logic         done;
    logic         illegal;
    logic [2:0]   readnum;
    logic [2:0]   writenum;
    logic         write;
    logic         loada;
    logic         loadb;
    logic         loadc;
    logic         loads;
    logic         asel;
    logic         bsel;
    logic         vsel;
    logic [1:0]   shift;
    logic [1:0]   ALUop;
    logic [W-1:0] sximm8;

    // Sequencer side
    modport master (
        input  start, instr,
        output busy, done, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8
    );

    // Requester/datapath side
    modport slave (
        output start, instr,
        input  busy, done, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the register-file/shifter/ALU datapath. Takes one
// instruction per start/done handshake and steps the datapath strobes in order.
module datapath_ctrl #(
    parameter int unsigned W = 16
) (
    input logic             clk,
    input logic             rst_n,
    datapath_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StWait, StDecode, StLoadA, StLoadB, StExec, StWriteImm, StWriteRes, StDone
    } state_e;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    state_e      state_q, state_d;
    logic [15:0] ir_q;
    logic        illegal_q;
    ctrl_t       ctrl_q, ctrl_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    // Every op under 101 is legal: ADD, CMP, AND, MVN
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // Next state, and the strobes that state will drive once registered
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        case (state_q)
            StWait:     if (bus.start) state_d = StDecode;
            StDecode: begin
                if (is_mov_imm)                 state_d = StWriteImm;
                else if (is_mov_reg || is_mvn)  state_d = StLoadB;
                else if (is_alu)                state_d = StLoadA;
                else                            state_d = StDone;
            end
            StLoadA:    state_d = StLoadB;
            StLoadB:    state_d = StExec;
            StExec:     state_d = is_cmp ? StDone : StWriteRes;
            StWriteImm: state_d = StDone;
            StWriteRes: state_d = StDone;
            StDone:     state_d = StWait;
            default:    state_d = StWait;
        endcase

        ctrl_d.busy = (state_d != StWait);
        ctrl_d.done = (state_d == StDone);
        // IR is already valid for every state past DECODE, which is strobe-free
        case (state_d)
            StLoadA: begin
                ctrl_d.readnum = rn;
                ctrl_d.loada   = 1'b1;
            end
            StLoadB: begin
                ctrl_d.readnum = rm;
                ctrl_d.loadb   = 1'b1;
            end
            StExec: begin
                ctrl_d.shift = sh;
                if (is_mov_reg) begin
                    ctrl_d.asel  = 1'b1;
                    ctrl_d.aluop = 2'b00;
                    ctrl_d.loadc = 1'b1;
                end else if (is_mvn) begin
                    ctrl_d.asel  = 1'b1;
                    ctrl_d.aluop = 2'b11;
                    ctrl_d.loadc = 1'b1;
                end else if (is_cmp) begin
                    ctrl_d.aluop = 2'b01;
                    ctrl_d.loads = 1'b1;
                end else begin
                    ctrl_d.aluop = op;
                    ctrl_d.loadc = 1'b1;
                end
            end
            StWriteImm: begin
                ctrl_d.writenum = rn;
                ctrl_d.vsel     = 1'b1;
                ctrl_d.write    = 1'b1;
            end
            StWriteRes: begin
                ctrl_d.writenum = rd;
                ctrl_d.write    = 1'b1;
            end
            default: ;
        endcase
    end

    // State, IR, illegal flag and registered strobes; reset aborts everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWait;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_q == StWait && bus.start) begin
                ir_q      <= bus.instr;
                illegal_q <= 1'b0;
            end else if (state_q == StDecode && state_d == StDone) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.busy     = ctrl_q.busy;
    assign bus.done     = ctrl_q.done;
    assign bus.illegal  = illegal_q;
    assign bus.readnum  = ctrl_q.readnum;
    assign bus.writenum = ctrl_q.writenum;
    assign bus.write    = ctrl_q.write;
    assign bus.loada    = ctrl_q.loada;
    assign bus.loadb    = ctrl_q.loadb;
    assign bus.loadc    = ctrl_q.loadc;
    assign bus.loads    = ctrl_q.loads;
    assign bus.asel     = ctrl_q.asel;
    assign bus.bsel     = 1'b0;
    assign bus.vsel     = ctrl_q.vsel;
    assign bus.shift    = ctrl_q.shift;
    assign bus.ALUop    = ctrl_q.aluop;
    assign bus.sximm8   = {{(W-8){ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: drives instructions, models the datapath the strobes
// steer, and checks each completed instruction against a queued expectation.
module tb_datapath_ctrl;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          writes;
        logic [2:0]  wnum;
        logic [15:0] wdata;
        logic        illegal;
        int          loads;
        logic        z;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    datapath_ctrl_if #(.W(16)) bus ();

    datapath_ctrl #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural datapath steered by the DUT strobes
    logic [15:0] regs [8];
    logic [15:0] a_m, b_m, c_m;
    logic        z_m;

    function automatic logic [15:0] shifter(input logic [15:0] b, input logic [1:0] s);
        case (s)
            2'b01:   return {b[14:0], 1'b0};
            2'b10:   return {1'b0, b[15:1]};
            2'b11:   return {b[15], b[15:1]};
            default: return b;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] f);
        case (f)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x & y;
            default: return ~y;
        endcase
    endfunction

    always @(posedge clk) begin : dp_model
        logic [15:0] res;
        res = alu(bus.asel ? 16'h0 : a_m, bus.bsel ? bus.sximm8 : shifter(b_m, bus.shift),
                  bus.ALUop);
        if (bus.loada) a_m <= regs[bus.readnum];
        if (bus.loadb) b_m <= regs[bus.readnum];
        if (bus.loadc) c_m <= res;
        if (bus.loads) z_m <= (res == 16'h0);
        if (bus.write) regs[bus.writenum] <= bus.vsel ? bus.sximm8 : c_m;
    end

    // Scoreboard monitor, sampled on the falling edge
    vec_t        sb [$];
    bit          active;
    int          cyc, writes, loads_n;
    logic [2:0]  wnum;
    logic [15:0] wdata;

    always @(negedge clk) begin : monitor
        vec_t e;
        if (!rst_n) begin
            active = 1'b0;
            if (bus.done) check("done_in_reset", bus.done, 1'b0);
            if (bus.write) check("write_in_reset", bus.write, 1'b0);
        end else begin
            if (active) begin
                cyc++;
                if (bus.write) begin
                    writes++;
                    wnum  = bus.writenum;
                    wdata = bus.vsel ? bus.sximm8 : c_m;
                end
                if (bus.loads) loads_n++;
                if (bus.done) begin
                    active = 1'b0;
                    check("done_has_expectation", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check($sformatf("latency[%h]", e.instr), cyc, e.lat);
                        check($sformatf("writes[%h]", e.instr), writes, e.writes);
                        check($sformatf("illegal[%h]", e.instr), bus.illegal, e.illegal);
                        check($sformatf("loads[%h]", e.instr), loads_n, e.loads);
                        if (e.writes != 0) begin
                            check($sformatf("writenum[%h]", e.instr), wnum, e.wnum);
                            check($sformatf("wdata[%h]", e.instr), wdata, e.wdata);
                        end
                        if (e.loads != 0) check($sformatf("z[%h]", e.instr), z_m, e.z);
                    end
                end
            end else begin
                if (bus.done) check("stray_done", bus.done, 1'b0);
                if (bus.write) check("stray_write", bus.write, 1'b0);
            end
            if (!bus.busy && bus.start) begin
                active  = 1'b1;
                cyc     = 0;
                writes  = 0;
                loads_n = 0;
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] instr, input int lat, input int writes,
                                input logic [2:0] wnum, input logic [15:0] wdata,
                                input logic illegal, input int loads, input logic z);
        vec_t v;
        v.instr = instr; v.lat = lat; v.writes = writes; v.wnum = wnum; v.wdata = wdata;
        v.illegal = illegal; v.loads = loads; v.z = z;
        return v;
    endfunction

    // One instruction: wait for WAIT, offer it, then toggle start/instr while busy
    task automatic run_instr(input vec_t v);
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            @(posedge clk); #1; n++;
        end
        bus.instr = v.instr;
        bus.start = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            bus.start = 1'($urandom_range(1));
            bus.instr = 16'($urandom);
            @(posedge clk); #1; n++;
        end
        bus.start = 1'b0;
        check($sformatf("drained[%h]", v.instr), sb.size(), 0);
        sb.delete();
    endtask

    vec_t tbl [14];
    vec_t b2b [3];

    initial begin
        int n;
        n_cmp  = 0;
        n_fail = 0;
        foreach (regs[i]) regs[i] = 16'h0;
        a_m = '0; b_m = '0; c_m = '0; z_m = 1'b0;
        bus.start = 1'b0;
        bus.instr = 16'h0;
        rst_n     = 1'b0;

        tbl[0]  = mk(16'hD007, 3, 1, 3'd0, 16'h0007, 1'b0, 0, 1'b0); // MOV R0,#7
        tbl[1]  = mk(16'hD102, 3, 1, 3'd1, 16'h0002, 1'b0, 0, 1'b0); // MOV R1,#2
        tbl[2]  = mk(16'hA148, 6, 1, 3'd2, 16'h0010, 1'b0, 0, 1'b0); // ADD R2,R1,R0,LSL#1
        tbl[3]  = mk(16'hA900, 5, 0, 3'd0, 16'h0000, 1'b0, 1, 1'b0); // CMP R1,R0
        tbl[4]  = mk(16'hD3FF, 3, 1, 3'd3, 16'hFFFF, 1'b0, 0, 1'b0); // MOV R3,#-1
        tbl[5]  = mk(16'hE000, 2, 0, 3'd0, 16'h0000, 1'b1, 0, 1'b0); // illegal opcode
        tbl[6]  = mk(16'hC001, 5, 1, 3'd0, 16'h0002, 1'b0, 0, 1'b0); // MOV R0,R1
        tbl[7]  = mk(16'hB860, 5, 1, 3'd3, 16'hFFFD, 1'b0, 0, 1'b0); // MVN R3,R0
        tbl[8]  = mk(16'hB393, 6, 1, 3'd4, 16'h7FFC, 1'b0, 0, 1'b0); // AND R4,R3,R3,LSR#1
        tbl[9]  = mk(16'hA3BB, 6, 1, 3'd5, 16'hFFFB, 1'b0, 0, 1'b0); // ADD R5,R3,R3,ASR#1
        tbl[10] = mk(16'hA901, 5, 0, 3'd0, 16'h0000, 1'b0, 1, 1'b1); // CMP R1,R1
        tbl[11] = mk(16'hC800, 2, 0, 3'd0, 16'h0000, 1'b1, 0, 1'b0); // 110/01 illegal
        tbl[12] = mk(16'hD800, 2, 0, 3'd0, 16'h0000, 1'b1, 0, 1'b0); // 110/11 illegal
        tbl[13] = mk(16'hD680, 3, 1, 3'd6, 16'hFF80, 1'b0, 0, 1'b0); // MOV R6,#-128

        b2b[0] = mk(16'hD405, 3, 1, 3'd4, 16'h0005, 1'b0, 0, 1'b0); // MOV R4,#5
        b2b[1] = mk(16'hC004, 5, 1, 3'd0, 16'h0005, 1'b0, 0, 1'b0); // MOV R0,R4
        b2b[2] = mk(16'hB8E0, 5, 1, 3'd7, 16'hFFFA, 1'b0, 0, 1'b0); // MVN R7,R0

        // Reset state
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_sximm8", bus.sximm8, 16'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Reset mid-ADD, asserted while LOAD_B is active
        @(posedge clk); #1;
        bus.instr = 16'hA148;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.loadb && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("abort_reached_loadb", bus.loadb, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_write", bus.write, 1'b0);
        check("abort_strobes", {bus.loada, bus.loadb, bus.loadc}, 3'b000);
        check("abort_done", bus.done, 1'b0);
        check("abort_ir_cleared", bus.sximm8, 16'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        foreach (tbl[i]) run_instr(tbl[i]);

        // Illegal flag holds through idle cycles until the next accepted start
        run_instr(tbl[5]);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_held", bus.illegal, 1'b1);
        check("idle_busy", bus.busy, 1'b0);
        run_instr(tbl[0]);
        check("illegal_cleared", bus.illegal, 1'b0);

        // Back-to-back with start held high and instr scrambled while busy
        bus.start = 1'b1;
        foreach (b2b[i]) begin
            bus.instr = b2b[i].instr;
            sb.push_back(b2b[i]);
            @(posedge clk); #1;
            n = 0;
            while (bus.busy && n < 50) begin
                bus.instr = 16'($urandom);
                @(posedge clk); #1; n++;
            end
            check($sformatf("b2b_busy_cycles[%h]", b2b[i].instr), n, b2b[i].lat);
        end
        bus.start = 1'b0;
        check("b2b_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_r7", regs[7], 16'hFFFA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
